// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared widths, depth, starvation limit and response/grant encodings.
package mem_port_arbiter_pkg;
  localparam int MEM_WIDTH = 32;
  localparam int MEM_SIZE = 256;
  localparam int ADDR_W = $clog2(MEM_SIZE);
  localparam int MAX_WAIT = 4;
  typedef enum logic [1:0] {RESP_NONE = 2'd0, RESP_INSTR = 2'd1, RESP_DATA = 2'd2} resp_t;
  typedef enum logic {GNT_INSTR = 1'b0, GNT_DATA = 1'b1} gnt_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: core fetch/data ports plus shared-memory port; slave side is the arbiter.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;
  logic i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr;
  logic [MEM_WIDTH-1:0] i_rdata;
  logic d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr;
  logic [MEM_WIDTH-1:0] d_wdata, d_rdata;
  logic addr_err, stall;
  logic mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_WIDTH-1:0] mem_wdata, mem_rdata;
  modport slave (
    input i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, addr_err, stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, addr_err, stall,
    input mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_wait_counter.sv
// mem_arb_wait_counter: saturating up-counter with clear; full flags the starvation limit.
module mem_arb_wait_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic full
);
  logic [3:0] cnt;
  assign full = cnt == 4'(MAX);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !full) cnt <= cnt + 4'd1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port memory shared by fetch and data ports, one grant per cycle.
// ARB_ROUND_ROBIN_EN selects alternating conflict winner instead of data priority with starvation guard.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  resp_t state, state_nx;
  logic i_ok, d_ok, i_win, addr_err_q;
  assign i_ok = bus.i_addr < 32'(MEM_SIZE);
  assign d_ok = bus.d_addr < 32'(MEM_SIZE);
  assign bus.addr_err = addr_err_q;
`ifdef ARB_ROUND_ROBIN_EN
  gnt_t last_gnt;
  assign i_win = last_gnt == GNT_DATA;
  always_ff @(posedge clk or posedge reset)
    if (reset) last_gnt <= GNT_INSTR;
    else if (bus.i_gnt || bus.d_gnt) last_gnt <= bus.d_gnt ? GNT_DATA : GNT_INSTR;
`else
  mem_arb_wait_counter #(.MAX(MAX_WAIT)) u_wait (
    .clk(clk),
    .reset(reset),
    .inc(bus.i_req && !bus.i_gnt),
    .clr(!bus.i_req || bus.i_gnt),
    .full(i_win)
  );
`endif
  always_comb begin
    bus.i_gnt = !reset && bus.i_req && (!bus.d_req || i_win);
    bus.d_gnt = !reset && bus.d_req && !(bus.i_req && i_win);
    bus.stall = (bus.i_req && !bus.i_gnt) || (bus.d_req && !bus.d_gnt);
    bus.mem_en = (bus.i_gnt && i_ok) || (bus.d_gnt && d_ok);
    bus.mem_we = bus.d_gnt && d_ok && bus.d_we;
    bus.mem_addr = bus.i_gnt ? bus.i_addr[ADDR_W-1:0] : bus.d_gnt ? bus.d_addr[ADDR_W-1:0] : '0;
    bus.mem_wdata = bus.mem_we ? bus.d_wdata : '0;
    state_nx = bus.i_gnt ? RESP_INSTR : (bus.d_gnt && !bus.d_we) ? RESP_DATA : RESP_NONE;
    bus.i_rvalid = state == RESP_INSTR;
    bus.d_rvalid = state == RESP_DATA;
    // an out-of-range read still completes, but with zero data
    bus.i_rdata = (bus.i_rvalid && !addr_err_q) ? bus.mem_rdata : '0;
    bus.d_rdata = (bus.d_rvalid && !addr_err_q) ? bus.mem_rdata : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RESP_NONE;
      addr_err_q <= 1'b0;
    end else begin
      state <= state_nx;
      addr_err_q <= (bus.i_gnt && !i_ok) || (bus.d_gnt && !d_ok);
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plus random checks of mem_port_arbiter against a cycle-level model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  mem_port_arbiter_if bus();
  mem_port_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mem [256];
  bit wr [256];
  logic [31:0] ref_mem [256];
  int wait_n = 0;
  bit last_d = 1'b0;
  bit exp_iv = 1'b0, exp_dv = 1'b0, exp_ae = 1'b0;
  logic [31:0] exp_ird = '0, exp_drd = '0;
  bit ir, dr, dw, gi, gd;
  logic [31:0] ia, da, wd;
  logic [5:0] pat, pat_exp;

  function automatic logic [31:0] seed(input logic [7:0] a);
    return a == 8'd5 ? 32'h2402000A : {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  function automatic logic [31:0] rnd_addr();
    int r = $urandom_range(0, 15);
    return r == 0 ? 32'($urandom) : r == 1 ? 32'(256 + $urandom_range(0, 99)) : 32'($urandom_range(0, 31));
  endfunction

  // memory array behind the arbiter: read data lands the cycle after mem_en
  always @(posedge clk)
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr] <= bus.mem_wdata;
        wr[bus.mem_addr] <= 1'b1;
      end else bus.mem_rdata <= wr[bus.mem_addr] ? mem[bus.mem_addr] : seed(bus.mem_addr);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    wait_n = 0;
    last_d = 1'b0;
    {exp_iv, exp_dv, exp_ae} = '0;
    exp_ird = '0;
    exp_drd = '0;
  endtask

  // one cycle: drive at the falling edge, check 1 time unit later, advance the model, wait for next falling edge
  task automatic step(input bit ir_i, input logic [31:0] ia_i, input bit dr_i, input bit dw_i,
                      input logic [31:0] da_i, input logic [31:0] wd_i, output bit gi_o, output bit gd_o);
    bit eig, edg, iok, dok;
    bus.i_req = ir_i; bus.i_addr = ia_i;
    bus.d_req = dr_i; bus.d_we = dw_i; bus.d_addr = da_i; bus.d_wdata = wd_i;
    #1;
    chk("i_rvalid", 32'(bus.i_rvalid), 32'(exp_iv));
    chk("i_rdata", bus.i_rdata, exp_ird);
    chk("d_rvalid", 32'(bus.d_rvalid), 32'(exp_dv));
    chk("d_rdata", bus.d_rdata, exp_drd);
    chk("addr_err", 32'(bus.addr_err), 32'(exp_ae));
    iok = ia_i < 32'd256;
    dok = da_i < 32'd256;
    if (ir_i && dr_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      eig = last_d;
`else
      eig = wait_n == 4;
`endif
      edg = !eig;
    end else begin
      eig = ir_i;
      edg = dr_i;
    end
    chk("i_gnt", 32'(bus.i_gnt), 32'(eig));
    chk("d_gnt", 32'(bus.d_gnt), 32'(edg));
    chk("stall", 32'(bus.stall), 32'((ir_i && !eig) || (dr_i && !edg)));
    chk("mem_en", 32'(bus.mem_en), 32'((eig && iok) || (edg && dok)));
    chk("mem_we", 32'(bus.mem_we), 32'(edg && dok && dw_i));
    if ((eig && iok) || (edg && dok)) chk("mem_addr", 32'(bus.mem_addr), eig ? 32'(ia_i[7:0]) : 32'(da_i[7:0]));
    if (edg && dok && dw_i) chk("mem_wdata", bus.mem_wdata, wd_i);
    exp_iv = eig;
    exp_ird = (eig && iok) ? ref_mem[ia_i[7:0]] : '0;
    exp_dv = edg && !dw_i;
    exp_drd = (exp_dv && dok) ? ref_mem[da_i[7:0]] : '0;
    exp_ae = (eig && !iok) || (edg && !dok);
    if (edg && dw_i && dok) ref_mem[da_i[7:0]] = wd_i;
    wait_n = (ir_i && !eig) ? (wait_n < 4 ? wait_n + 1 : 4) : 0;
    if (eig || edg) last_d = edg;
    gi_o = eig;
    gd_o = edg;
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) ref_mem[k] = seed(8'(k));
    bus.i_req = 1'b1; bus.i_addr = 32'd5;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'd3; bus.d_wdata = '0;
    @(negedge clk);
    #1;
    chk("rst_i_gnt", 32'(bus.i_gnt), 32'd0);
    chk("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd1);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_rvalid", 32'({bus.i_rvalid, bus.d_rvalid, bus.addr_err}), 32'd0);
    chk("rst_rdata", bus.i_rdata | bus.d_rdata, 32'd0);
    reset = 1'b0;
    model_reset();

    step(1'b1, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0, gi, gd);
    #1 chk("fetch5", bus.i_rdata, 32'h2402000A);
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, gi, gd);

    pat = '0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 32'd8, 1'b1, 1'b0, 32'(k), 32'd0, gi, gd);
      pat[k] = gi;
    end
`ifdef ARB_ROUND_ROBIN_EN
    pat_exp = 6'b101010;
`else
    pat_exp = 6'b010000;
`endif
    chk("conflict_seq", 32'(pat), 32'(pat_exp));
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, gi, gd);

    step(1'b0, 32'd0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, gi, gd);
    #1 chk("wr_no_rvalid", 32'(bus.d_rvalid), 32'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h10, 32'd0, gi, gd);
    #1 chk("rd_back", bus.d_rdata, 32'hDEADBEEF);
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, gi, gd);

    step(1'b0, 32'd0, 1'b1, 1'b0, 32'd300, 32'd0, gi, gd);
    #1 chk("oor_err", 32'({bus.addr_err, bus.d_rvalid}), 32'b11);
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, gi, gd);
    step(1'b1, 32'h0100_0005, 1'b0, 1'b0, 32'd0, 32'd0, gi, gd);
    step(1'b0, 32'd0, 1'b1, 1'b1, 32'h8000_0010, 32'h12345678, gi, gd);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h10, 32'd0, gi, gd);
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, gi, gd);

    // reset lands after the grant but before the edge that would register it
    bus.i_req = 1'b1; bus.i_addr = 32'd7; bus.d_req = 1'b0;
    #1 chk("pre_rst_gnt", 32'(bus.i_gnt), 32'd1);
    reset = 1'b1;
    #1 chk("rst_forces_gnt", 32'(bus.i_gnt), 32'd0);
    @(negedge clk);
    chk("rst_no_rvalid", 32'(bus.i_rvalid), 32'd0);
    bus.i_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1 chk("post_rst_no_rvalid", 32'(bus.i_rvalid), 32'd0);
    @(negedge clk);
    step(1'b1, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0, gi, gd);
    chk("post_rst_first_gnt", 32'(gi), 32'd1);

    ir = 1'b0;
    dr = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!ir) begin
        ir = $urandom_range(0, 2) != 0;
        ia = rnd_addr();
      end
      if (!dr) begin
        dr = $urandom_range(0, 2) != 0;
        dw = 1'($urandom_range(0, 1));
        da = rnd_addr();
        wd = $urandom;
      end
      step(ir, ia, dr, dw, da, wd, gi, gd);
      if (gi) ir = 1'b0;
      if (gd) dr = 1'b0;
    end
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, gi, gd);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
